// File: rtl/fault_pkg.sv
// Shared types for the fault LED sequencer: event encoding, FIFO entry layout, FSM states.
package fault_pkg;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'd0,
        EVT_IFAULT = 2'd1,
        EVT_PBLOCK = 2'd2,
        EVT_BDROP  = 2'd3
    } evt_type_e;

    localparam int unsigned UNIT_MAX = 2;
    localparam int unsigned EVT_W    = 4;

    typedef struct packed {
        logic [1:0] unit;
        evt_type_e  etype;
    } evt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    function automatic logic evt_is_valid(evt_t e);
        return (e.unit <= 2'(UNIT_MAX)) && (e.etype != EVT_NONE);
    endfunction

    // Flag vector ordered {b_drop, p_block, i_fault}
    function automatic logic [2:0] evt_flags(evt_type_e t);
        logic [2:0] f;
        f = 3'b000;
        case (t)
            EVT_IFAULT: f = 3'b001;
            EVT_PBLOCK: f = 3'b010;
            EVT_BDROP:  f = 3'b100;
            default:    f = 3'b000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fault_evt_fifo.sv
// Synchronous FIFO for fault events; power-of-two depth, registered occupancy count.
module fault_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fault_led_sequencer.sv
// Buffers fault events and presents them one at a time on the LED flags with hold and gap.
// Build option FAULT_SEQ_DEDUP_EN drops a repeat of the newest entry while it is queued or shown.
module fault_led_sequencer
    import fault_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       evt_valid,
    input  logic [1:0] evt_unit,
    input  logic [1:0] evt_type,
    output logic       evt_ready,
    output logic [1:0] unitlist,
    output logic       i_fault,
    output logic       p_block,
    output logic       b_drop,
    output logic       busy,
    output logic       err_pulse
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    seq_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       unit_q, unit_d;
    logic [2:0]       flags_q, flags_d;
    logic             err_q, err_d;

    evt_t             in_evt;
    evt_t             head;
    logic [EVT_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             xfer;
    logic             dup;
    logic             push;
    logic             pop;
    logic             load;

    assign in_evt = evt_t'({evt_unit, evt_type});
    assign head   = evt_t'(fifo_rdata);
    assign xfer   = evt_valid && !fifo_full;
    assign push   = xfer && evt_is_valid(in_evt) && !dup;
    assign err_d  = xfer && !evt_is_valid(in_evt);

`ifdef FAULT_SEQ_DEDUP_EN
    evt_t last_q;

    // The newest write is live while the FIFO holds anything or while it is being shown
    always_ff @(posedge clk_50M) begin
        if (reset)     last_q <= '0;
        else if (push) last_q <= in_evt;
    end

    assign dup = (!fifo_empty || (state_q == SHOW)) && (in_evt == last_q);
`else
    assign dup = 1'b0;
`endif

    fault_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk_i   (clk_50M),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (in_evt),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            unit_q  <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            unit_q  <= unit_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    // A gap expiring with a backlog starts the next event directly, so queued events
    // are spaced exactly HOLD_CYCLES + GAP_CYCLES apart.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unit_d  = unit_q;
        flags_d = flags_q;
        load    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: load = !fifo_empty;
            SHOW: begin
                if (timer_q == '0) begin
                    flags_d = '0;
                    timer_d = TMR_W'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    load    = !fifo_empty;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            pop     = 1'b1;
            unit_d  = head.unit;
            flags_d = evt_flags(head.etype);
            timer_d = TMR_W'(HOLD_CYCLES - 1);
            state_d = SHOW;
        end
    end

    assign evt_ready = !fifo_full;
    assign busy      = (state_q != IDLE) || (fifo_count != '0);
    assign unitlist  = unit_q;
    assign i_fault   = flags_q[0];
    assign p_block   = flags_q[1];
    assign b_drop    = flags_q[2];
    assign err_pulse = err_q;

endmodule

// File: tb/tb_fault_led_sequencer.sv
// Bench for fault_led_sequencer: event-schedule reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fault_led_sequencer;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int GAP   = 2;

    logic       clk_50M   = 1'b0;
    logic       reset     = 1'b1;
    logic       evt_valid = 1'b0;
    logic [1:0] evt_unit  = 2'd0;
    logic [1:0] evt_type  = 2'd0;
    logic       evt_ready;
    logic [1:0] unitlist;
    logic       i_fault;
    logic       p_block;
    logic       b_drop;
    logic       busy;
    logic       err_pulse;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;
    bit err_prev = 1'b0;

    // Accepted events: arrival cycle, first display cycle, unit, type
    int ev_arr[$];
    int ev_start[$];
    int ev_unit[$];
    int ev_type[$];

    fault_led_sequencer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .evt_valid (evt_valid),
        .evt_unit  (evt_unit),
        .evt_type  (evt_type),
        .evt_ready (evt_ready),
        .unitlist  (unitlist),
        .i_fault   (i_fault),
        .p_block   (p_block),
        .b_drop    (b_drop),
        .busy      (busy),
        .err_pulse (err_pulse)
    );

    always #5 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    function automatic int model_ready(int t);
        int n;
        n = 0;
        foreach (ev_arr[i]) if (ev_arr[i] + 1 <= t && t <= ev_start[i] - 1) n++;
        return (n < DEPTH) ? 1 : 0;
    endfunction

    function automatic int model_is_dup(int t, int u, int ty);
`ifdef FAULT_SEQ_DEDUP_EN
        int n;
        n = ev_arr.size();
        if (n == 0) return 0;
        return (ev_unit[n-1] == u && ev_type[n-1] == ty &&
                ev_arr[n-1] + 1 <= t && t <= ev_start[n-1] + HOLD - 1) ? 1 : 0;
`else
        return (t < 0 && u == ty) ? 1 : 0;
`endif
    endfunction

    // Per-cycle compare against the schedule model, then fold in this cycle's transfer
    always @(negedge clk_50M) begin
        int t, e_flags, e_unit, e_busy, e_ready, st, u, ty;
        bit err_next;
        t = cyc;
        err_next = 1'b0;
        e_ready = model_ready(t);
        if (armed) begin
            e_flags = 0;
            e_unit  = 0;
            e_busy  = 0;
            foreach (ev_start[i]) begin
                if (ev_start[i] <= t) e_unit = ev_unit[i];
                if (ev_start[i] <= t && t < ev_start[i] + HOLD) e_flags = 1 << (ev_type[i] - 1);
                if (ev_arr[i] + 1 <= t && t < ev_start[i] + HOLD + GAP) e_busy = 1;
            end
            chk("model_flags", int'({b_drop, p_block, i_fault}), e_flags);
            chk("model_unitlist", int'(unitlist), e_unit);
            chk("model_busy", int'(busy), e_busy);
            chk("model_ready", int'(evt_ready), e_ready);
            chk("model_err_pulse", int'(err_pulse), int'(err_prev));
        end
        if (reset) begin
            ev_arr.delete();
            ev_start.delete();
            ev_unit.delete();
            ev_type.delete();
            armed = 1'b1;
        end else if (armed && evt_valid && e_ready == 1) begin
            u  = int'(evt_unit);
            ty = int'(evt_type);
            if (u == 3 || ty == 0) begin
                err_next = 1'b1;
            end else if (model_is_dup(t, u, ty) == 0) begin
                st = t + 2;
                if (ev_start.size() > 0 && ev_start[$] + HOLD + GAP > st)
                    st = ev_start[$] + HOLD + GAP;
                ev_arr.push_back(t);
                ev_start.push_back(st);
                ev_unit.push_back(u);
                ev_type.push_back(ty);
            end
        end
        err_prev = err_next;
    end

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic drive(bit v, int u, int ty);
        tick();
        evt_valid = v;
        evt_unit  = 2'(u);
        evt_type  = 2'(ty);
    endtask

    // Offers an event and keeps offering until it transfers; returns 2 time units into that cycle
    task automatic send(int u, int ty);
        int k;
        drive(1'b1, u, ty);
        #1;
        k = 0;
        while (!evt_ready && k < 100) begin
            tick();
            #1;
            k++;
        end
        if (!evt_ready) timeout_fail("send_ready");
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_idle(int budget);
        int k;
        drive(1'b0, 0, 0);
        k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        if (busy) timeout_fail("wait_idle");
    endtask

    initial begin
        int base;
        repeat (2) @(posedge clk_50M);
        #1;
        reset = 1'b0;
        chk("reset_flags", int'({b_drop, p_block, i_fault}), 0);
        chk("reset_unitlist", int'(unitlist), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(evt_ready), 1);

        // Single event: shown cycles 2..5, gap 6..7, idle from 8
        send(1, 2);
        base = cyc;
        drive(1'b0, 0, 0);
        wait_cyc(base + 2);
        chk("single_pblock_c2", int'(p_block), 1);
        chk("single_unit_c2", int'(unitlist), 1);
        wait_cyc(base + 5);
        chk("single_pblock_c5", int'(p_block), 1);
        wait_cyc(base + 6);
        chk("single_gap_c6", int'({b_drop, p_block, i_fault}), 0);
        chk("single_unit_hold_c6", int'(unitlist), 1);
        wait_cyc(base + 8);
        chk("single_busy_c8", int'(busy), 0);

        // Burst of six: fifth fills the FIFO, sixth waits for the pop after the first gap
        wait_idle(100);
        send(0, 1);
        base = cyc;
        send(1, 2);
        send(2, 3);
        #5;
        chk("burst_first_ifault", int'(i_fault), 1);
        send(0, 2);
        send(1, 3);
        drive(1'b1, 2, 1);
        chk("burst_sixth_refused", int'(evt_ready), 0);
        #1;
        for (int k = 0; k < 20 && !evt_ready; k++) begin
            tick();
            #1;
        end
        chk("burst_sixth_accept_cycle", cyc, base + 8);
        chk("burst_second_shown", int'({b_drop, p_block, i_fault}), 2);
        chk("burst_second_unit", int'(unitlist), 1);

        // Invalid events are consumed, pulse once each, never queued
        wait_idle(200);
        send(3, 1);
        send(0, 0);
        chk("err_after_inv1", int'(err_pulse), 1);
        drive(1'b0, 0, 0);
        chk("err_after_inv2", int'(err_pulse), 1);
        tick();
        chk("err_single_pulse", int'(err_pulse), 0);
        chk("inv_no_flag", int'({b_drop, p_block, i_fault}), 0);
        chk("inv_not_busy", int'(busy), 0);

        // Reset while showing with three queued
        wait_idle(100);
        send(0, 1);
        base = cyc;
        send(1, 1);
        send(2, 2);
        send(0, 3);
        drive(1'b0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_flags", int'({b_drop, p_block, i_fault}), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(evt_ready), 1);

        // Same event twice in a row
        wait_idle(100);
        send(2, 3);
        base = cyc;
        send(2, 3);
        drive(1'b0, 0, 0);
        wait_cyc(base + 2);
        chk("dup_first_bdrop", int'(b_drop), 1);
        wait_cyc(base + 6);
        chk("dup_gap", int'(b_drop), 0);
        wait_cyc(base + 8);
`ifdef FAULT_SEQ_DEDUP_EN
        chk("dup_second_bdrop", int'(b_drop), 0);
`else
        chk("dup_second_bdrop", int'(b_drop), 1);
`endif

        // Randomized traffic with occasional invalid, repeated and reset cycles
        wait_idle(100);
        for (int i = 0; i < 900; i++) begin
            tick();
            if ($urandom_range(0, 249) == 0) begin
                reset     = 1'b1;
                evt_valid = 1'b0;
            end else begin
                reset     = 1'b0;
                evt_valid = ($urandom_range(0, 99) < 35);
                if ($urandom_range(0, 9) == 0) begin
                    evt_unit = 2'($urandom_range(0, 3));
                    evt_type = 2'($urandom_range(0, 3));
                end else if ($urandom_range(0, 3) != 0) begin
                    evt_unit = 2'($urandom_range(0, 2));
                    evt_type = 2'($urandom_range(1, 3));
                end
            end
        end
        tick();
        reset = 1'b0;
        wait_idle(200);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
